inv_mix_columns_iter: RTL



---
 rtl/aes_pkg.sv | 47 ++++
 rtl/inv_mix_column.sv | 21 ++
 rtl/inv_mix_columns_iter.sv | 82 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, iterative-unit state encodings and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational AES InvMixColumns transform of a single 32-bit column (row 0 in the MSBs).
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] s0, s1, s2, s3;

    assign s0 = col_i[31:24];
    assign s1 = col_i[23:16];
    assign s2 = col_i[15:8];
    assign s3 = col_i[7:0];

    assign col_o[31:24] = gf_mul14(s0) ^ gf_mul11(s1) ^ gf_mul13(s2) ^ gf_mul9(s3);
    assign col_o[23:16] = gf_mul9(s0)  ^ gf_mul14(s1) ^ gf_mul11(s2) ^ gf_mul13(s3);
    assign col_o[15:8]  = gf_mul13(s0) ^ gf_mul9(s1)  ^ gf_mul14(s2) ^ gf_mul11(s3);
    assign col_o[7:0]   = gf_mul11(s0) ^ gf_mul13(s1) ^ gf_mul9(s2)  ^ gf_mul14(s3);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: one column per clock through a shared column unit,
// result held in the working register until the downstream handshake.
module inv_mix_columns_iter
    import aes_pkg::*;
(
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [AES_BLOCK_W-1:0] InData,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [AES_BLOCK_W-1:0] OutData,
    output logic                   Busy
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       col_cnt_q, col_cnt_d;
    logic [3:0][31:0] data_q, data_d;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       col_idx;
    logic [31:0]      col_in, col_out;

    // Column 0 sits in the MSBs, i.e. packed element 3.
    assign col_idx = 2'd3 - col_cnt_q;
    assign col_in  = data_q[col_idx];

    inv_mix_column u_inv_mix_column (
        .col_i(col_in),
        .col_o(col_out)
    );

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        data_d    = data_q;
        case (state_q)
            StIdle: begin
                if (InValid && in_ready_q) begin
                    data_d    = InData;
                    col_cnt_d = 2'd0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                data_d[col_idx] = col_out;
                col_cnt_d       = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (OutReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so InReady stays low while reset is asserted.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= StIdle;
            col_cnt_q  <= 2'd0;
            data_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_cnt_q  <= col_cnt_d;
            data_q     <= data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = (state_q == StDone);
    assign OutData  = data_q;
    assign Busy     = (state_q == StCalc) || (state_q == StDone);

endmodule
